fifo_stream_reader: RTL
=======================

# fifo_stream_reader

Read-side engine for the team's synchronous FIFO. It pops words from the FIFO through its `rd_en`/`empty`/`data_out` port, accounting for the FIFO's one-cycle registered read latency. It re-presents the words on a valid/ready output stream without loss, duplication or reordering, and it sustains one word per cycle when the consumer is always ready. It sits between a FIFO instance and any downstream consumer (serializer, packer, output port).

## Interface
Parameters:
- `DATAWIDTH`, 8: word width; must equal the paired FIFO's `DATAWIDTH`.
- `CNT_WIDTH`, 16: width of the transfer counter.

Ports (one clock; reset is synchronous and active-low):
- `clk` in 1: single clock, rising edge; same clock as the FIFO.
- `rst_n` in 1: synchronous, active-low reset.
- `enable` in 1: permits new FIFO reads; it does not gate delivery of words already fetched.
- `fifo_empty` in 1: FIFO `empty` flag.
- `fifo_rd_en` out 1: FIFO `rd_en`.
- `fifo_data` in DATAWIDTH: FIFO `data_out`. It is valid in the cycle after an accepted read and is ignored otherwise.
- `m_valid` out 1: output word valid.
- `m_data` out DATAWIDTH: output word.
- `m_ready` in 1: consumer accepts when `m_valid & m_ready`.
- `xfer_cnt` out CNT_WIDTH: count of completed output transfers.
- `busy` out 1: a read is in flight or a word is buffered.

## Operation
- **State:**
  - 2-entry output buffer: head = `m_data`, plus a skid entry; occupancy `occ` ∈ {0,1,2}.
  - `inflight` flag: set for the cycle after `fifo_rd_en` was high.
- **Read issue (combinational):** `fifo_rd_en = rst_n & enable & !fifo_empty & (occ + inflight - pop < 2)`, where `pop = m_valid & m_ready`.
  - A read is issued only when the buffer is guaranteed to have space for its data.
  - The path from `m_ready` to `fifo_rd_en` is combinational by design; it is required for full throughput.
- **Capture:** when `inflight` is 1, `fifo_data` is written into the buffer at the clock edge.
  - If the buffer is empty, or pops this cycle with no skid entry, the word goes to the head; otherwise it goes to the skid entry.
- **Pop:** on `m_valid & m_ready`:
  - the skid entry (if any) moves to the head, and
  - the captured word fills the next free slot in the same edge.
- **Ordering:** strictly the FIFO pop order. Each accepted FIFO read produces exactly one output transfer.
- **Output stability:** while `m_valid & !m_ready`, `m_data` and `m_valid` hold unchanged.
- **`m_data` when idle:** `m_data` holds its last value when `m_valid` is 0. It is 0 after reset.
- **Counter:** `xfer_cnt` increments by 1 per pop and wraps modulo 2^CNT_WIDTH.
- **Status:** `busy = inflight | (occ != 0)`.
- **`enable` low:** no new reads are issued; the in-flight word and buffered words still drain normally.
- **Reset:** while `rst_n` = 0:
  - `fifo_rd_en` = 0 (combinationally forced).
  - `m_valid` = 0, `m_data` = 0, `occ` = 0, `inflight` = 0, `xfer_cnt` = 0, `busy` = 0.
  - Reset mid-operation discards buffered and in-flight words; the FIFO is reset by the same system reset.

## Timing
- **Read-to-output latency:** 2 cycles.
  - `fifo_rd_en` high in cycle N → `fifo_data` valid in N+1 → `m_valid` = 1 with that word in N+2.
- **Throughput:** 1 word/cycle with `m_ready` held 1 and the FIFO non-empty.
  - Steady state: `occ` = 1, `inflight` = 1, `fifo_rd_en` = 1 every cycle.
- **Backpressure:** after `m_ready` drops, at most one more read is issued (fills the skid entry).
  - `fifo_rd_en` stays 0 while `occ + inflight` = 2.
  - Resumes in the same cycle that `m_ready` returns high.
- **Simultaneous events:** capture and pop in the same cycle leave `occ` unchanged.
  - Capture with no pop: `occ` +1.
  - Pop with no capture: `occ` −1.
- **Reads while empty:** no read is ever issued while `fifo_empty` = 1, even if `enable` = 1.
- **Reset exit:** the first `fifo_rd_en` can assert in the first cycle with `rst_n` = 1.

## Test plan
- **Reset:** hold `rst_n` = 0 for 3 cycles with `enable` = 1, `fifo_empty` = 0, `m_ready` = 1 → `fifo_rd_en` = 0, `m_valid` = 0, `m_data` = 0, `xfer_cnt` = 0, `busy` = 0 every cycle.
- **Streaming:** preload the FIFO with 0x01..0x08, `enable` = 1, `m_ready` = 1 → `fifo_rd_en` high for 8 consecutive cycles; `m_valid` high for 8 consecutive cycles starting 2 cycles after the first read, carrying 0x01..0x08 in order; `xfer_cnt` = 8; `busy` = 0 afterwards.
- **Backpressure:** same preload, `m_ready` = 0 from the first `m_valid` for 5 cycles → `m_data` holds 0x01 stable; `fifo_rd_en` = 0 once `occ + inflight` = 2. After release, 0x01..0x08 are delivered once each, in order.
- **Empty gaps:** the FIFO receives 0xA0, 0xA1, then 0xA2 four cycles later → no `fifo_rd_en` while `fifo_empty` = 1; output is 0xA0, 0xA1, (gap), 0xA2; `xfer_cnt` = 3.
- **Enable drop:** drop `enable` in the cycle after a read is issued, with 4 words left in the FIFO → the in-flight word is delivered, no further reads occur, and the FIFO keeps 4 words; `busy` falls after delivery.
- **Counter wrap and mid-reset:** with `CNT_WIDTH` = 4, 17 transfers → `xfer_cnt` = 1. Then assert `rst_n` = 0 with `occ` = 2 → `m_valid` = 0 and `xfer_cnt` = 0 at the next edge.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// ============================================================================
// fifo_stream_reader : pops a registered-read FIFO onto a valid/ready stream
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module fifo_stream_reader #(
  parameter int DATAWIDTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  input  logic                 fifo_empty,
  output logic                 fifo_rd_en,
  input  logic [DATAWIDTH-1:0] fifo_data,
  output logic                 m_valid,
  output logic [DATAWIDTH-1:0] m_data,
  input  logic                 m_ready,
  output logic [CNT_WIDTH-1:0] xfer_cnt,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  logic [1:0]           r_occ;
  logic                 r_inflight;
  logic [DATAWIDTH-1:0] r_head;
  logic [DATAWIDTH-1:0] r_skid;
  logic [CNT_WIDTH-1:0] r_cnt;

  logic                 w_pop;
  logic [2:0]           w_level;

  // w_level is the occupancy after this edge; occ + inflight never exceeds 2,
  // so it also decides whether one more read still has a guaranteed slot.
  always_comb begin
    m_valid    = (r_occ != 2'd0);
    w_pop      = m_valid & m_ready;
    w_level    = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    fifo_rd_en = rst_n & enable & ~fifo_empty & (w_level < 3'd2);
    busy       = r_inflight | (r_occ != 2'd0);
    m_data     = r_head;
    xfer_cnt   = r_cnt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_occ      <= 2'd0;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_skid     <= '0;
      r_cnt      <= '0;
    end else begin
      r_inflight <= fifo_rd_en;
      r_occ      <= w_level[1:0];
      if (w_pop) begin
        r_cnt <= r_cnt + c_CNT_ONE;
      end
      // Full buffer popping: skid advances and any captured word refills it.
      if (w_pop && (r_occ == 2'd2)) begin
        r_head <= r_skid;
        if (r_inflight) begin
          r_skid <= fifo_data;
        end
      end else if (r_inflight) begin
        if ((r_occ == 2'd0) || ((r_occ == 2'd1) && w_pop)) begin
          r_head <= fifo_data;
        end else begin
          r_skid <= fifo_data;
        end
      end
    end
  end

endmodule

`default_nettype wire
